// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// IMEM request/response, redirect and decode handshake signals of the fetch unit.
interface instr_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_misaligned
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_misaligned
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two fetch queue; flush beats push, and a push into a full queue is accepted when paired with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  entry_t                 data_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i & ~flush_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q + PTR_W'(do_push);
        rd_d  = rd_q + PTR_W'(do_pop);
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity comes from the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC, RUN/HALT control and fetch queue toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             marker_q, marker_d;

    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             push;
    logic             flush;
    logic             pop;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;

    assign pop = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        marker_d   = marker_q;
        push       = 1'b0;
        flush      = 1'b0;
        push_entry = '{pc: pc_q, inst: bus.imem_inst, misaligned: 1'b0};
        if (bus.redirect_valid) begin
            flush    = 1'b1;
            pc_d     = bus.redirect_pc;
            marker_d = |bus.redirect_pc[1:0];
            state_d  = (|bus.redirect_pc[1:0]) ? HALT : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if ((fifo_cnt < CNT_W'(FIFO_DEPTH)) || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                HALT: begin
                    // One marker per misaligned redirect; pc parks on the bad target.
                    if (marker_q && (!fifo_full || pop)) begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_q, inst: NOP_INST, misaligned: 1'b1};
                        marker_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            marker_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            marker_q <= marker_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .head_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.imem_addr      = pc_q;
    assign bus.out_valid      = ~fifo_empty;
    assign bus.out_pc         = fifo_empty ? 32'h0 : head.pc;
    assign bus.out_inst       = fifo_empty ? NOP_INST : head.inst;
    assign bus.out_misaligned = fifo_empty ? 1'b0 : head.misaligned;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.redirect_valid) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
